// File: rtl/ucsbece154b_perfmon.sv
// Branch/jump performance monitor: six live event counters plus a snapshot/shadow read port.
// Build option: define PERFMON_SATURATE_EN to make counters stick at all-ones instead of wrapping.
module ucsbece154b_perfmon (
    input  logic        clk,
    input  logic        reset,
    input  logic        BranchTakenF_i,
    input  logic        StallD_i,
    input  logic        FlushD_i,
    input  logic        FlushE_i,
    input  logic        ValidE_i,
    input  logic [6:0]  opE_i,
    input  logic        MispredictE_i,
    input  logic        freeze_i,
    input  logic        clear_i,
    input  logic        snap_req_i,
    output logic        snap_valid_o,
    input  logic        snap_ack_i,
    input  logic [2:0]  sel_i,
    output logic [31:0] data_o
);

    // state  | meaning
    // IDLE   | no snapshot held, waiting for snap_req_i
    // HELD   | shadow registers frozen and valid, waiting for snap_ack_i
    typedef enum logic {S_IDLE, S_HELD} state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t            state_q, state_d;
    logic [5:0][31:0]  cnt_q, cnt_d;
    logic [5:0][31:0]  shadow_q, shadow_d;
    logic              pred_d_q, pred_d_d;
    logic              pred_e_q, pred_e_d;
    logic [5:0]        inc;
    logic              is_br, is_jmp;

    function automatic logic [31:0] bump(input logic [31:0] v);
`ifdef PERFMON_SATURATE_EN
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
`else
        return v + 32'd1;
`endif
    endfunction

    always_comb begin
        pred_d_d = pred_d_q;
        if (!StallD_i) pred_d_d = FlushD_i ? 1'b0 : BranchTakenF_i;
        pred_e_d = FlushE_i ? 1'b0 : pred_d_q;
    end

    // Index order matches the sel_i read map: CYC, INST, BR, BRMISS, JMP, JMPMISS
    always_comb begin
        is_br  = ValidE_i && (opE_i == OP_BRANCH);
        is_jmp = ValidE_i && ((opE_i == OP_JAL) || (opE_i == OP_JALR));
        inc[0] = 1'b1;
        inc[1] = ValidE_i;
        inc[2] = is_br;
        inc[3] = is_br && MispredictE_i;
        inc[4] = is_jmp;
        inc[5] = is_jmp && !pred_e_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!freeze_i) begin
            for (int i = 0; i < 6; i++) begin
                if (inc[i]) cnt_d[i] = bump(cnt_q[i]);
            end
        end
    end

    // Shadow captures the pre-update live values so a snapshot is a clean cut of one cycle
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (snap_req_i) begin
                    shadow_d = cnt_q;
                    state_d  = S_HELD;
                end
            end
            S_HELD: begin
                if (snap_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            pred_d_q <= 1'b0;
            pred_e_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pred_d_q <= pred_d_d;
            pred_e_q <= pred_e_d;
        end
    end

    assign snap_valid_o = (state_q == S_HELD);

    always_comb begin
        data_o = 32'd0;
        case (sel_i)
            3'd0: data_o = shadow_q[0];
            3'd1: data_o = shadow_q[1];
            3'd2: data_o = shadow_q[2];
            3'd3: data_o = shadow_q[3];
            3'd4: data_o = shadow_q[4];
            3'd5: data_o = shadow_q[5];
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ucsbece154b_perfmon.sv
// Self-checking bench for ucsbece154b_perfmon: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_ucsbece154b_perfmon;

    logic        clk = 1'b0;
    logic        reset, BranchTakenF_i, StallD_i, FlushD_i, FlushE_i, ValidE_i;
    logic [6:0]  opE_i;
    logic        MispredictE_i, freeze_i, clear_i, snap_req_i, snap_ack_i;
    logic [2:0]  sel_i;
    logic        snap_valid_o;
    logic [31:0] data_o;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    ucsbece154b_perfmon dut (
        .clk(clk), .reset(reset), .BranchTakenF_i(BranchTakenF_i),
        .StallD_i(StallD_i), .FlushD_i(FlushD_i), .FlushE_i(FlushE_i),
        .ValidE_i(ValidE_i), .opE_i(opE_i), .MispredictE_i(MispredictE_i),
        .freeze_i(freeze_i), .clear_i(clear_i), .snap_req_i(snap_req_i),
        .snap_valid_o(snap_valid_o), .snap_ack_i(snap_ack_i),
        .sel_i(sel_i), .data_o(data_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: live counters, shadow copy, held flag, predictions in D and E
    logic [31:0] m_cnt [6];
    logic [31:0] m_sh  [6];
    bit          m_held, m_pd, m_pe;

    function automatic logic [31:0] m_inc(input logic [31:0] v);
`ifdef PERFMON_SATURATE_EN
        if (v == 32'hFFFF_FFFF) return v;
`endif
        return v + 32'd1;
    endfunction

    task automatic model_step();
        bit br, jmp, npd, npe;
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin m_cnt[i] = 0; m_sh[i] = 0; end
            m_held = 0; m_pd = 0; m_pe = 0;
            return;
        end
        if (!m_held && snap_req_i) begin
            for (int i = 0; i < 6; i++) m_sh[i] = m_cnt[i];
            m_held = 1;
        end else if (m_held && snap_ack_i) begin
            m_held = 0;
        end
        br  = ValidE_i && opE_i == OP_BR;
        jmp = ValidE_i && (opE_i == OP_JAL || opE_i == OP_JALR);
        if (clear_i) begin
            for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        end else if (!freeze_i) begin
            m_cnt[0] = m_inc(m_cnt[0]);
            if (ValidE_i)             m_cnt[1] = m_inc(m_cnt[1]);
            if (br)                   m_cnt[2] = m_inc(m_cnt[2]);
            if (br && MispredictE_i)  m_cnt[3] = m_inc(m_cnt[3]);
            if (jmp)                  m_cnt[4] = m_inc(m_cnt[4]);
            if (jmp && !m_pe)         m_cnt[5] = m_inc(m_cnt[5]);
        end
        npd = StallD_i ? m_pd : (FlushD_i ? 1'b0 : BranchTakenF_i);
        npe = FlushE_i ? 1'b0 : m_pd;
        m_pd = npd;
        m_pe = npe;
    endtask

    task automatic check_outputs();
        logic [31:0] exp;
        exp = (sel_i < 3'd6) ? m_sh[sel_i] : 32'd0;
        tests++;
        if (snap_valid_o !== m_held) begin
            fails++;
            $display("FAIL snap_valid t=%0t got %b want %b", $time, snap_valid_o, m_held);
        end
        tests++;
        if (data_o !== exp) begin
            fails++;
            $display("FAIL data_o sel=%0d t=%0t got %h want %h", sel_i, $time, data_o, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Pins both the DUT read port and the model's shadow against a hand-derived value
    task automatic check_sel(input int s, input logic [31:0] exp);
        sel_i = s[2:0];
        #1;
        check_lit($sformatf("data_o[sel=%0d]", s), data_o, exp);
        if (s < 6) check_lit($sformatf("model_shadow[%0d]", s), m_sh[s], exp);
    endtask

    task automatic idle_inputs();
        reset = 1; BranchTakenF_i = 0; StallD_i = 0; FlushD_i = 0; FlushE_i = 0;
        ValidE_i = 0; opE_i = 7'd0; MispredictE_i = 0; freeze_i = 0; clear_i = 0;
        snap_req_i = 0; snap_ack_i = 0; sel_i = 0;
    endtask

    task automatic snap_take();
        snap_req_i = 1; cycle(); snap_req_i = 0;
    endtask

    task automatic snap_release_and_clear();
        snap_ack_i = 1; cycle(); snap_ack_i = 0;
        clear_i = 1; cycle(); clear_i = 0;
    endtask

    logic [6:0]       prog_op  [7];
    bit               prog_btf [7];
    bit               prog_mis [7];
    logic [5:0][31:0] fvec;
    logic [31:0]      exp_wrap;

    initial begin
        idle_inputs();
        reset = 0;
        @(negedge clk);
        cycle(); cycle();
        check_lit("reset_valid", {31'd0, snap_valid_o}, 32'd0);
        check_sel(0, 32'd0);

        // Ten idle cycles then a snapshot
        reset = 1;
        repeat (10) cycle();
        snap_take();
        check_lit("idle_valid", {31'd0, snap_valid_o}, 32'd1);
        check_sel(0, 32'd10);
        check_sel(1, 32'd0);
        check_sel(3, 32'd0);
        snap_req_i = 1;
        repeat (3) cycle();
        snap_req_i = 0;
        check_lit("held_valid", {31'd0, snap_valid_o}, 32'd1);
        check_sel(0, 32'd10);
        snap_release_and_clear();
        check_lit("ack_valid", {31'd0, snap_valid_o}, 32'd0);

        // Branch / jump mix with no stalls: fetch slot k reaches Execute two cycles later
        prog_op  = '{OP_BR, OP_BR, OP_BR, OP_BR, OP_JAL, OP_JAL, OP_JALR};
        prog_btf = '{0, 0, 0, 0, 1, 1, 0};
        prog_mis = '{0, 1, 0, 0, 0, 0, 0};
        for (int k = 0; k < 9; k++) begin
            BranchTakenF_i = (k < 7) ? prog_btf[k] : 1'b0;
            ValidE_i       = (k >= 2);
            opE_i          = (k >= 2) ? prog_op[k-2] : 7'd0;
            MispredictE_i  = (k >= 2) ? prog_mis[k-2] : 1'b0;
            cycle();
        end
        idle_inputs();
        snap_take();
        check_sel(0, 32'd9);
        check_sel(1, 32'd7);
        check_sel(2, 32'd4);
        check_sel(3, 32'd1);
        check_sel(4, 32'd3);
        check_sel(5, 32'd1);
        check_sel(6, 32'd0);
        check_sel(7, 32'd0);
        snap_release_and_clear();

        // Stalled jal, flushed before Execute (f=1) or delivered (f=0)
        for (int f = 1; f >= 0; f--) begin
            BranchTakenF_i = 1; cycle(); BranchTakenF_i = 0;
            StallD_i = 1; cycle(); cycle(); StallD_i = 0;
            FlushE_i = (f == 1); cycle(); FlushE_i = 0;
            ValidE_i = (f == 0); opE_i = OP_JAL; cycle();
            idle_inputs();
            snap_take();
            check_sel(4, (f == 1) ? 32'd0 : 32'd1);
            check_sel(5, 32'd0);
            snap_release_and_clear();
        end

        // Clear+freeze while a snapshot of INST=7 is held
        ValidE_i = 1; opE_i = OP_ALU;
        repeat (7) cycle();
        idle_inputs();
        snap_take();
        check_sel(1, 32'd7);
        clear_i = 1; freeze_i = 1; cycle(); clear_i = 0; freeze_i = 0;
        check_sel(1, 32'd7);
        check_lit("clear_keeps_held", {31'd0, snap_valid_o}, 32'd1);
        cycle();
        check_sel(1, 32'd7);
        snap_ack_i = 1; cycle(); snap_ack_i = 0;
        snap_take();
        check_sel(1, 32'd0);
        check_sel(0, 32'd2);
        snap_ack_i = 1; cycle(); snap_ack_i = 0;

        // Counter near the top of its range
        m_cnt[0] = 32'hFFFF_FFFE;
        for (int i = 0; i < 6; i++) fvec[i] = m_cnt[i];
        force dut.cnt_q = fvec;
        #1;
        release dut.cnt_q;
        repeat (3) cycle();
        snap_take();
`ifdef PERFMON_SATURATE_EN
        exp_wrap = 32'hFFFF_FFFF;
`else
        exp_wrap = 32'h0000_0001;
`endif
        check_sel(0, exp_wrap);

        // Reset while a snapshot is held
        reset = 0; cycle(); reset = 1;
        check_lit("reset_held_valid", {31'd0, snap_valid_o}, 32'd0);
        for (int s = 0; s < 6; s++) check_sel(s, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) != 0);
            BranchTakenF_i = $urandom_range(0, 1) == 1;
            StallD_i       = $urandom_range(0, 4) == 0;
            FlushD_i       = $urandom_range(0, 5) == 0;
            FlushE_i       = $urandom_range(0, 5) == 0;
            ValidE_i       = $urandom_range(0, 9) < 7;
            case ($urandom_range(0, 4))
                0: opE_i = OP_BR;
                1: opE_i = OP_JAL;
                2: opE_i = OP_JALR;
                3: opE_i = OP_ALU;
                default: opE_i = 7'($urandom);
            endcase
            MispredictE_i  = $urandom_range(0, 2) == 0;
            freeze_i       = $urandom_range(0, 9) == 0;
            clear_i        = $urandom_range(0, 39) == 0;
            snap_req_i     = $urandom_range(0, 4) == 0;
            snap_ack_i     = $urandom_range(0, 4) == 0;
            sel_i          = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_perfmon.md
UCSBECE154B_PERFMON -- requirements
Module: ucsbece154b_perfmon

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset asserted, sampled on rising clk).
REQ-003 SHALL have port BranchTakenF_i, input, 1, predictor taken flag for the instruction in Fetch.
REQ-004 SHALL have ports StallD_i, FlushD_i, FlushE_i, input, 1 each, pipeline hazard controls matching the datapath's.
REQ-005 SHALL have port ValidE_i, input, 1, a real (non-bubble) instruction occupies Execute.
REQ-006 SHALL have port opE_i, input, 7, opcode of the instruction in Execute.
REQ-007 SHALL have port MispredictE_i, input, 1, Execute-stage branch resolution disagrees with prediction.
REQ-008 SHALL have ports freeze_i (hold all counters) and clear_i (zero all counters), input, 1 each.
REQ-009 SHALL have ports snap_req_i (input, 1), snap_valid_o (output, 1), snap_ack_i (input, 1), snapshot handshake.
REQ-010 SHALL have ports sel_i, input, 3, and data_o, output, 32, snapshot read mux.

Function
REQ-011 SHALL carry the prediction flag F->D->E: predD holds on StallD_i, else loads 0 on FlushD_i, else BranchTakenF_i; predE loads 0 on FlushE_i, else predD.
REQ-012 SHALL keep six 32-bit live counters: CYC, INST, BR, BRMISS, JMP, JMPMISS.
REQ-013 SHALL increment CYC every non-reset, non-frozen cycle.
REQ-014 SHALL increment INST when ValidE_i=1.
REQ-015 SHALL increment BR when ValidE_i=1 and opE_i=1100011; BRMISS additionally when MispredictE_i=1.
REQ-016 SHALL increment JMP when ValidE_i=1 and opE_i is 1101111 or 1100111; JMPMISS additionally when predE=0.
REQ-017 SHALL make each increment visible in the counter one cycle after the qualifying Execute cycle (1-cycle latency).
REQ-018 SHALL, with freeze_i=1, hold all live counters; the prediction pipeline keeps advancing.
REQ-019 SHALL give clear_i priority over freeze_i and increments: all live counters 0 next cycle, no event counted that cycle.
REQ-020 SHALL implement snapshot FSM with states IDLE and HELD.
REQ-021 SHALL, in IDLE on snap_req_i=1, copy all six live counters (pre-increment values of that cycle) into shadow registers and enter HELD.
REQ-022 SHALL assert snap_valid_o=1 exactly while in HELD; shadow registers are stable in HELD; snap_req_i in HELD is ignored.
REQ-023 SHALL return HELD->IDLE on snap_ack_i=1; snap_ack_i in IDLE is ignored; simultaneous snap_req_i and snap_ack_i in HELD -> IDLE only.
REQ-024 SHALL drive data_o combinationally from shadow: sel 0..5 = CYC, INST, BR, BRMISS, JMP, JMPMISS; sel 6,7 = 0.
REQ-025 SHALL not let clear_i alter shadow registers or FSM state.

Reset
REQ-026 SHALL, while reset=0, zero all live counters, shadow registers, predD, predE, and set FSM to IDLE.
REQ-027 SHALL give reset priority over every other input, including mid-HELD (snap_valid_o=0 next cycle, data_o=0).
REQ-028 SHALL count nothing in a cycle where reset=0 is sampled.

Configuration
REQ-029 SHALL honour macro PERFMON_SATURATE_EN: defined -> every counter holds at 0xFFFFFFFF on further increments; undefined -> counters wrap 0xFFFFFFFF->0x00000000.

Verification
REQ-030 Reset then 10 idle cycles with ValidE_i=0, snap handshake -> CYC=10, INST=0, others 0, snap_valid_o=1 until ack.
REQ-031 4 branches in E with MispredictE_i=1 on 1 of them, 2 jal with BranchTakenF_i=1 and 1 jalr with BranchTakenF_i=0 (no stalls) -> BR=4, BRMISS=1, JMP=3, JMPMISS=1.
REQ-032 jal fetched with BranchTakenF_i=1, StallD_i=1 for 2 cycles then FlushE_i=1 before it reaches E with ValidE_i=0 -> JMP=0, JMPMISS=0; same without flush -> JMP=1, JMPMISS=0.
REQ-033 Counter forced near 0xFFFFFFFE, 3 increments -> 0xFFFFFFFF with PERFMON_SATURATE_EN, 0x00000001 without.
REQ-034 clear_i and freeze_i both 1 while INST=7, snapshot held -> live INST=0 next cycle, data_o(sel=1) still 7 until new snapshot.
REQ-035 reset=0 asserted while in HELD -> snap_valid_o=0 and all data_o=0 next cycle.
